pep_ldg_gram_wr: RTL and testbench

- Reception stage downstream of the GLWE load entry.
- Consumes the load command (main or subs split) and the coefficient stream carved from AXI read data.
- Writes one GLWE body per command into its GRAM slice, one AXI word per write, addressed by pid.
- Pulses cmd_done once the last word of the body is committed to GRAM.

---
 rtl/pep_ldg_gram_wr.sv | 133 +++++++++++++
 tb/tb_pep_ldg_gram_wr.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pep_ldg_gram_wr.sv
// GLWE load reception: writes one body per load command into the GRAM slice addressed by cmd pid.
// Optional macro PEP_LDG_GRAM_WR_COEF_CHECK_EN flags coefficients >= MOD_Q; pid is cmd[PID_W-1:0].
module pep_ldg_gram_wr #(
    parameter int unsigned        COEF_PER_WORD   = 8,
    parameter int unsigned        MOD_Q_W         = 32,
    parameter int unsigned        WORD_PER_BODY   = 64,
    parameter int unsigned        PID_W           = 6,
    parameter int unsigned        GRAM_ADD_W      = 12,
    parameter int unsigned        LOAD_GLWE_CMD_W = 32,
    parameter logic [MOD_Q_W-1:0] MOD_Q           = '1
) (
    input  logic                             clk,
    input  logic                             s_rst_n,
    input  logic [LOAD_GLWE_CMD_W-1:0]       cmd,
    input  logic                             cmd_vld,
    output logic                             cmd_rdy,
    output logic                             cmd_done,
    input  logic [COEF_PER_WORD*MOD_Q_W-1:0] data,
    input  logic                             data_vld,
    output logic                             data_rdy,
    output logic                             gram_wr_en,
    output logic [GRAM_ADD_W-1:0]            gram_wr_add,
    output logic [COEF_PER_WORD*MOD_Q_W-1:0] gram_wr_data,
    input  logic                             gram_wr_gnt,
    output logic                             error
);

    localparam int unsigned DW         = COEF_PER_WORD * MOD_Q_W;
    localparam int unsigned CNT_W      = $clog2(WORD_PER_BODY);
    localparam int unsigned IDLE_CNT_W = $clog2(WORD_PER_BODY + 1);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(WORD_PER_BODY - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = IDLE_CNT_W'(WORD_PER_BODY);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

    state_e                  state;
    state_e                  state_n;
    logic [GRAM_ADD_W-1:0]   base;
    logic [CNT_W-1:0]        word_cnt;
    logic [IDLE_CNT_W-1:0]   idle_cnt;
    logic                    s1_vld;
    logic [GRAM_ADD_W-1:0]   s1_add;
    logic [DW-1:0]           s1_data;
    logic                    data_acc;
    logic                    s1_commit;
    logic                    stream_err;
    logic                    coef_err;

    logic unused_cmd;
    assign unused_cmd = ^cmd[LOAD_GLWE_CMD_W-1:PID_W];

    assign data_acc  = data_vld && data_rdy;
    assign s1_commit = s1_vld && gram_wr_gnt;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_vld && cmd_rdy) state_n = LOAD;
            LOAD:    if (data_acc && word_cnt == LAST_CNT) state_n = FLUSH;
            FLUSH:   if (s1_commit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        data_rdy     = (state == LOAD) && (!s1_vld || gram_wr_gnt);
        cmd_done     = (state == DONE);
        gram_wr_en   = s1_vld;
        gram_wr_add  = s1_add;
        gram_wr_data = s1_data;
    end

    // cmd_rdy is registered so it stays low while reset is held
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cmd_rdy  <= 1'b0;
            base     <= '0;
            word_cnt <= '0;
            s1_vld   <= 1'b0;
            s1_add   <= '0;
            s1_data  <= '0;
        end else begin
            cmd_rdy <= (state_n == IDLE);
            if (state == IDLE && cmd_vld && cmd_rdy)
                base <= GRAM_ADD_W'(cmd[PID_W-1:0]) * GRAM_ADD_W'(WORD_PER_BODY);
            if (data_acc) begin
                s1_vld   <= 1'b1;
                s1_add   <= base + GRAM_ADD_W'(word_cnt);
                s1_data  <= data;
                word_cnt <= (word_cnt == LAST_CNT) ? '0 : word_cnt + CNT_W'(1);
            end else if (s1_commit) begin
                s1_vld <= 1'b0;
            end
        end
    end

    assign stream_err = (state == IDLE) && data_vld && (idle_cnt == IDLE_MAX);

`ifdef PEP_LDG_GRAM_WR_COEF_CHECK_EN
    logic coef_ovf;
    always_comb begin
        coef_ovf = 1'b0;
        for (int unsigned i = 0; i < COEF_PER_WORD; i++)
            if (data[i*MOD_Q_W +: MOD_Q_W] >= MOD_Q) coef_ovf = 1'b1;
    end
    assign coef_err = data_acc && coef_ovf;
`else
    logic unused_mod_q;
    assign unused_mod_q = ^MOD_Q;
    assign coef_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            idle_cnt <= '0;
            error    <= 1'b0;
        end else begin
            if (state == IDLE && data_vld) begin
                if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
            end else begin
                idle_cnt <= '0;
            end
            if (stream_err || coef_err) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pep_ldg_gram_wr.sv
// Directed self-checking bench for pep_ldg_gram_wr (default build or PEP_LDG_GRAM_WR_COEF_CHECK_EN).
module tb_pep_ldg_gram_wr;

    localparam int unsigned DW = 256;
    localparam int unsigned GA = 12;
    localparam int unsigned CW = 32;
`ifdef PEP_LDG_GRAM_WR_COEF_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          s_rst_n = 1'b0;
    logic [CW-1:0] cmd = '0;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy;
    logic          cmd_done;
    logic [DW-1:0] data = '0;
    logic          data_vld = 1'b0;
    logic          data_rdy;
    logic          gram_wr_en;
    logic [GA-1:0] gram_wr_add;
    logic [DW-1:0] gram_wr_data;
    logic          gram_wr_gnt = 1'b1;
    logic          error;

    int checks = 0;
    int errors = 0;

    pep_ldg_gram_wr #(
        .COEF_PER_WORD(8),
        .MOD_Q_W(32),
        .WORD_PER_BODY(64),
        .PID_W(6),
        .GRAM_ADD_W(12),
        .LOAD_GLWE_CMD_W(32),
        .MOD_Q(32'hFFFF_0001)
    ) dut (
        .clk(clk),
        .s_rst_n(s_rst_n),
        .cmd(cmd),
        .cmd_vld(cmd_vld),
        .cmd_rdy(cmd_rdy),
        .cmd_done(cmd_done),
        .data(data),
        .data_vld(data_vld),
        .data_rdy(data_rdy),
        .gram_wr_en(gram_wr_en),
        .gram_wr_add(gram_wr_add),
        .gram_wr_data(gram_wr_data),
        .gram_wr_gnt(gram_wr_gnt),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] word_of(input int seed, input int idx, input bit inj);
        logic [DW-1:0] w;
        for (int j = 0; j < 8; j++) w[j*32 +: 32] = {8'(seed), 8'(idx), 8'(j), 8'hA5};
        if (inj && idx == 5) w[31:0] = 32'hFFFF_0001;
        return w;
    endfunction

    task automatic send_cmd(input int pid);
        int n = 0;
        cmd     = CW'(pid);
        cmd_vld = 1'b1;
        while (!cmd_rdy && n < 10) begin
            tick();
            n++;
        end
        check("cmd_rdy_wait", cmd_rdy, 1);
        tick();
        cmd_vld = 1'b0;
    endtask

    // One full body; optionally keeps another command pending during it.
    task automatic run_body(input int pid, input int seed, input bit toggle, input bit inject,
                            input bit hold_vld, input int hold_pid);
        int sent = 0, commits = 0, done_cnt = 0;
        int c_first = -1, c_last = -1, c_done = -1, c_rdy = -1, acc5 = -1;
        bit rdy_viol = 0, hold_viol = 0, prev_stall = 0;
        logic [GA-1:0] prev_add = '0;
        logic [DW-1:0] prev_data = '0;
        logic [GA-1:0] base;
        base = GA'(pid * 64);
        send_cmd(pid);
        cmd_vld = hold_vld;
        cmd     = CW'(hold_pid);
        for (int cyc = 0; cyc < 400; cyc++) begin
            data_vld    = (sent < 64);
            data        = word_of(seed, sent, inject);
            gram_wr_gnt = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (done_cnt == 0 && cmd_rdy) rdy_viol = 1;
            if (prev_stall && !(gram_wr_en && gram_wr_add == prev_add && gram_wr_data == prev_data))
                hold_viol = 1;
            prev_stall = gram_wr_en && !gram_wr_gnt;
            prev_add   = gram_wr_add;
            prev_data  = gram_wr_data;
            if (gram_wr_en && gram_wr_gnt) begin
                check("wr_add", gram_wr_add, base + commits);
                check("wr_data", gram_wr_data, word_of(seed, commits, inject));
                if (commits == 0) c_first = cyc;
                c_last = cyc;
                commits++;
            end
            if (inject && acc5 >= 0 && cyc == acc5 + 1) check("coef_err", error, EXP_ERR);
            if (data_vld && data_rdy) begin
                if (inject && sent == 5) begin
                    acc5 = cyc;
                    check("err_before_bad", error, 0);
                end
                sent++;
            end
            if (cmd_done) begin
                done_cnt++;
                c_done = cyc;
            end
            if (done_cnt > 0 && cmd_rdy) begin
                c_rdy = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        data_vld = 1'b0;
        check("commits", commits, 64);
        check("done_cnt", done_cnt, 1);
        check("done_lat", c_done - c_last, 1);
        check("rdy_gap", c_rdy - c_done, 1);
        check("rdy_low_load", rdy_viol, 0);
        check("stall_hold", hold_viol, 0);
        if (!toggle) check("wr_span", c_last - c_first, 63);
    endtask

    initial begin
        int first_err = -1;
        bit stream_viol = 0;

        // Reset state
        #2;
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_data_rdy", data_rdy, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_wr_en", gram_wr_en, 0);
        check("rst_wr_add", gram_wr_add, 0);
        check("rst_wr_data", gram_wr_data, 0);
        check("rst_error", error, 0);
        tick();
        tick();
        s_rst_n = 1'b1;
        tick();
        check("rdy_after_rst", cmd_rdy, 1);

        // pid 3 with grant held, then with grant toggling
        run_body(3, 1, 0, 0, 0, 0);
        run_body(3, 2, 1, 0, 0, 0);

        // Back-to-back pid 0 then pid 63 with the second command pending
        run_body(0, 3, 0, 0, 1, 63);
        run_body(63, 4, 0, 0, 0, 0);
        check("err_clean", error, 0);

        // Stream without a command
        gram_wr_gnt = 1'b1;
        data_vld    = 1'b1;
        data        = word_of(7, 0, 0);
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (data_rdy || gram_wr_en) stream_viol = 1;
            if (error && first_err < 0) first_err = i;
        end
        check("stream_no_wr", stream_viol, 0);
        check("stream_err_cyc", first_err, 65);
        data_vld = 1'b0;
        tick();
        tick();
        check("err_sticky", error, 1);
        s_rst_n = 1'b0;
        #1;
        check("err_rst", error, 0);
        tick();
        s_rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of pid 1
        send_cmd(1);
        for (int i = 0; i < 21; i++) begin
            data_vld    = 1'b1;
            data        = word_of(9, i, 0);
            gram_wr_gnt = 1'b1;
            tick();
        end
        data_vld = 1'b0;
        check("pre_rst_wr_en", gram_wr_en, 1);
        check("pre_rst_wr_add", gram_wr_add, 64 + 20);
        #2;
        s_rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", gram_wr_en, 0);
        check("mid_rst_wr_add", gram_wr_add, 0);
        check("mid_rst_wr_data", gram_wr_data, 0);
        check("mid_rst_cmd_rdy", cmd_rdy, 0);
        check("mid_rst_done", cmd_done, 0);
        tick();
        s_rst_n = 1'b1;
        tick();
        run_body(2, 11, 0, 0, 0, 0);

        // Out-of-range coefficient in word 5
        run_body(4, 12, 0, 1, 0, 0);
        check("coef_err_final", error, EXP_ERR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
